exec_unit: RTL
==============

// Module: exec_unit
// PURPOSE
//  Parametrised execution unit: ALU + bank of NACC accumulators + CY/Z flag register.
//  Accepts one instruction per handshake; single-cycle ALU ops, multi-cycle shift-add MUL.
//  Sits between decoder and data bus; operand A is always the selected accumulator.
// PARAMETERS
//  WIDTH  8  data/accumulator width in bits (>=2)
//  NACC   4  number of accumulators (>=1); AW = (NACC>1) ? $clog2(NACC) : 1
// PORTS
//  clk         in   1      clock; all state changes on rising edge
//  rst         in   1      synchronous, active-high reset
//  in_valid    in   1      instruction present on op/acc_sel/in_b
//  in_ready    out  1      unit can accept an instruction (state IDLE)
//  op          in   4      operation code (table below)
//  acc_sel     in   AW     accumulator index; operand A and destination
//  in_b        in   WIDTH  operand B
//  out_valid   out  1      one-cycle pulse: instruction retired
//  out_result  out  WIDTH  value written to destination accumulator (held until next retire)
//  out_cy      out  1      current carry flag
//  out_z       out  1      current zero flag
// BEHAVIOUR
//  Reset: all accumulators, CY, Z, out_result = 0; out_valid = 0; in_ready = 1; state IDLE.
//  Accept = in_valid & in_ready at a rising edge. in_ready = (state==IDLE); it never depends on in_valid.
//  acc_sel >= NACC: instruction is accepted and retired with no accumulator or flag write; out_result = 0.
//  Opcodes (A = acc[acc_sel], B = in_b; all arithmetic mod 2^WIDTH):
//   0 NOP  no write, flags kept, still retires; 1 LD A=B; 2 ADD A=A+B; 3 ADC A=A+B+CY
//   4 SUB A=A-B (CY=borrow); 5 SBB A=A-B-CY (CY=borrow); 6 AND; 7 OR; 8 XOR; 9 NOT A=~A
//   A SHL {CY,A}={A,CY}; B SHR {A,CY}={CY,A}; C ROL; D ROR (rotate without CY, CY=bit shifted out)
//   E MUL A=low WIDTH bits of A*B (unsigned), CY = |high half; F CLC CY=0, no acc write
//  Flags: CY updated by 2-5,A-F; unchanged by 1,6-9. Z = (result==0) for every op that writes A.
//  Single-cycle ops (all except E): result/flags written at accept edge; out_valid=1 in the
//   following cycle only; in_ready stays 1, back-to-back accept every cycle allowed.
//  MUL FSM: IDLE -accept op E-> MUL (latch A,B,sel; clear partial product, counter=0)
//   MUL: each cycle add shifted multiplicand if multiplier bit set; counter++;
//   after WIDTH cycles in MUL -> IDLE with write at that edge; out_valid next cycle.
//   Latency accept->out_valid = WIDTH+1 cycles; in_ready=0 throughout MUL.
//  Inputs ignored while in_ready=0; operands captured at accept (changes later are harmless).
//  rst during MUL: abort, no accumulator/flag write, no out_valid; all to reset values.
//  ADC/SBB and SHL/SHR chains use CY as left by the immediately preceding retired op.
// TESTING
//  1 Reset: assert rst 2 cycles -> all acc=0, CY=0, Z=0, in_ready=1, out_valid=0.
//  2 WIDTH=8: LD acc0=0xFF; ADD B=0x01 -> result 0x00, CY=1, Z=1; ADC B=0x00 -> 0x01, CY=0, Z=0.
//  3 SUB acc1=0x10 B=0x20 -> 0xF0, CY=1; SBB B=0x00 -> 0xEF, CY=0; SHL 0x81 (CY=0) -> 0x02, CY=1.
//  4 MUL acc2=0x12 B=0x10 -> in_ready low 8 cycles, out_valid at cycle 9, result 0x20, CY=1;
//    0x03*0x05 -> 0x0F, CY=0; in_valid held high during MUL causes no extra accept.
//  5 Back-to-back: LD acc0..acc3 = 1,2,3,4 on consecutive cycles -> 4 out_valid pulses, each acc distinct.
//  6 rst mid-MUL (cycle 4): no out_valid, acc unchanged from reset (0), next instruction accepted normally.

Source files
------------

// File: rtl/exec_unit.sv
// Execution unit: ALU, accumulator bank, CY/Z flags, shift-add multiplier.
// One instruction per valid/ready handshake; MUL occupies WIDTH extra cycles.
module exec_unit #(
   parameter int WIDTH = 8,
   parameter int NACC  = 4,
   localparam int AW   = (NACC > 1) ? $clog2(NACC) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [AW-1:0]    acc_sel,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_result,
   output logic             out_cy,
   output logic             out_z
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LD  = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_ADC = 4'h3;
   localparam logic [3:0] OP_SUB = 4'h4;
   localparam logic [3:0] OP_SBB = 4'h5;
   localparam logic [3:0] OP_AND = 4'h6;
   localparam logic [3:0] OP_OR  = 4'h7;
   localparam logic [3:0] OP_XOR = 4'h8;
   localparam logic [3:0] OP_NOT = 4'h9;
   localparam logic [3:0] OP_SHL = 4'hA;
   localparam logic [3:0] OP_SHR = 4'hB;
   localparam logic [3:0] OP_ROL = 4'hC;
   localparam logic [3:0] OP_ROR = 4'hD;
   localparam logic [3:0] OP_MUL = 4'hE;
   localparam logic [3:0] OP_CLC = 4'hF;

   typedef enum logic {
      ST_IDLE,
      ST_MUL
   } state_t;

   state_t state_q, state_d;

   logic [WIDTH-1:0]   acc [NACC];
   logic               cy, z;
   logic               sel_ok, accept;
   logic [WIDTH-1:0]   a_val;

   logic [WIDTH-1:0]   res;
   logic [WIDTH:0]     t;
   logic [WIDTH:0]     cyw;
   logic               cy_n, wr, upd_cy;

   logic [2*WIDTH-1:0] mul_a, prod, prod_n;
   logic [WIDTH-1:0]   mul_b;
   logic [CW-1:0]      cnt;
   logic [AW-1:0]      mul_sel;
   logic               mul_ok, mul_last;

   assign sel_ok   = 32'(acc_sel) < 32'(NACC);
   assign a_val    = sel_ok ? acc[acc_sel] : '0;
   assign in_ready = (state_q == ST_IDLE);
   assign accept   = in_valid && in_ready;
   assign out_cy   = cy;
   assign out_z    = z;
   assign cyw      = {{WIDTH{1'b0}}, cy};
   assign prod_n   = prod + (mul_b[0] ? mul_a : '0);
   assign mul_last = (cnt == CW'(WIDTH - 1));

   always_comb begin
      res    = a_val;
      cy_n   = cy;
      wr     = 1'b0;
      upd_cy = 1'b0;
      t      = '0;
      unique case (op)
         OP_NOP: ;
         OP_LD: begin
            res = in_b;
            wr  = 1'b1;
         end
         OP_ADD, OP_ADC: begin
            t = {1'b0, a_val} + {1'b0, in_b}
              + ((op == OP_ADC) ? cyw : '0);
            res    = t[WIDTH-1:0];
            cy_n   = t[WIDTH];
            wr     = 1'b1;
            upd_cy = 1'b1;
         end
         // top bit of the widened difference is the borrow
         OP_SUB, OP_SBB: begin
            t = {1'b0, a_val} - {1'b0, in_b}
              - ((op == OP_SBB) ? cyw : '0);
            res    = t[WIDTH-1:0];
            cy_n   = t[WIDTH];
            wr     = 1'b1;
            upd_cy = 1'b1;
         end
         OP_AND: begin
            res = a_val & in_b;
            wr  = 1'b1;
         end
         OP_OR: begin
            res = a_val | in_b;
            wr  = 1'b1;
         end
         OP_XOR: begin
            res = a_val ^ in_b;
            wr  = 1'b1;
         end
         OP_NOT: begin
            res = ~a_val;
            wr  = 1'b1;
         end
         OP_SHL: begin
            res    = {a_val[WIDTH-2:0], cy};
            cy_n   = a_val[WIDTH-1];
            wr     = 1'b1;
            upd_cy = 1'b1;
         end
         OP_SHR: begin
            res    = {cy, a_val[WIDTH-1:1]};
            cy_n   = a_val[0];
            wr     = 1'b1;
            upd_cy = 1'b1;
         end
         OP_ROL: begin
            res    = {a_val[WIDTH-2:0], a_val[WIDTH-1]};
            cy_n   = a_val[WIDTH-1];
            wr     = 1'b1;
            upd_cy = 1'b1;
         end
         OP_ROR: begin
            res    = {a_val[0], a_val[WIDTH-1:1]};
            cy_n   = a_val[0];
            wr     = 1'b1;
            upd_cy = 1'b1;
         end
         OP_MUL: ;
         OP_CLC: begin
            cy_n   = 1'b0;
            upd_cy = 1'b1;
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (accept && op == OP_MUL) state_d = ST_MUL;
         ST_MUL:  if (mul_last) state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NACC; i++) acc[i] <= '0;
         cy         <= 1'b0;
         z          <= 1'b0;
         out_result <= '0;
         out_valid  <= 1'b0;
         mul_a      <= '0;
         mul_b      <= '0;
         prod       <= '0;
         cnt        <= '0;
         mul_sel    <= '0;
         mul_ok     <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (state_q == ST_IDLE) begin
            if (accept && op == OP_MUL) begin
               mul_a   <= {{WIDTH{1'b0}}, a_val};
               mul_b   <= in_b;
               prod    <= '0;
               cnt     <= '0;
               mul_sel <= acc_sel;
               mul_ok  <= sel_ok;
            end else if (accept) begin
               out_valid <= 1'b1;
               if (sel_ok) begin
                  out_result <= res;
                  if (wr) begin
                     acc[acc_sel] <= res;
                     z            <= (res == '0);
                  end
                  if (upd_cy) cy <= cy_n;
               end else begin
                  out_result <= '0;
               end
            end
         end else begin
            prod  <= prod_n;
            mul_a <= mul_a << 1;
            mul_b <= mul_b >> 1;
            cnt   <= cnt + 1'b1;
            if (mul_last) begin
               out_valid <= 1'b1;
               if (mul_ok) begin
                  acc[mul_sel] <= prod_n[WIDTH-1:0];
                  out_result   <= prod_n[WIDTH-1:0];
                  cy           <= |prod_n[2*WIDTH-1:WIDTH];
                  z            <= (prod_n[WIDTH-1:0] == '0);
               end else begin
                  out_result <= '0;
               end
            end
         end
      end
   end

endmodule
